// File: rtl/parking_ctrl_p.sv
// Parking-lot occupancy controller with a university reservation that shrinks
// hour by hour after RELEASE_HOUR; all status outputs are registered.
module parking_ctrl_p #(
    parameter int CAP_TOTAL     = 700,
    parameter int UNI_CAP_BASE  = 500,
    parameter int UNI_CAP_STEP  = 50,
    parameter int UNI_CAP_MIN   = 200,
    parameter int RELEASE_HOUR  = 13,
    parameter int START_HOUR    = 8,
    parameter int END_HOUR      = 24,
    parameter int CLKS_PER_HOUR = 1,
    parameter int CW            = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          car_entered,
    input  logic          is_uni_car_entered,
    input  logic          car_exited,
    input  logic          is_uni_car_exited,
    output logic [CW-1:0] uni_parked_cars,
    output logic [CW-1:0] parked_cars,
    output logic [CW-1:0] uni_vacated_space,
    output logic [CW-1:0] vacated_space,
    output logic          uni_is_vacated_space,
    output logic          is_vacated_space,
    output logic [4:0]    hour,
    output logic          entry_rejected,
    output logic          exit_error
);

    localparam int PW = (CLKS_PER_HOUR > 1) ? $clog2(CLKS_PER_HOUR) : 1;

    logic [PW-1:0] r_presc;
    logic [4:0]    r_hour;
    logic [CW-1:0] r_uni_cnt;
    logic [CW-1:0] r_pub_cnt;
    logic [CW-1:0] r_uni_vac;
    logic [CW-1:0] r_pub_vac;
    logic          r_uni_flag;
    logic          r_pub_flag;
    logic          r_entry_rej;
    logic          r_exit_err;

    logic          w_tick;
    logic [CW-1:0] w_uni_cap;
    logic [CW-1:0] w_pub_cap;
    logic [CW-1:0] w_uni_cnt_nxt;
    logic [CW-1:0] w_pub_cnt_nxt;
    logic [CW-1:0] w_uni_vac_nxt;
    logic [CW-1:0] w_pub_vac_nxt;
    logic          w_uni_inc;
    logic          w_uni_dec;
    logic          w_pub_inc;
    logic          w_pub_dec;
    logic          w_rej_nxt;
    logic          w_err_nxt;

    function automatic logic [CW-1:0] uni_cap_f(input logic [4:0] h);
        int dec;
        if (int'(h) <= RELEASE_HOUR) begin
            return CW'(UNI_CAP_BASE);
        end else begin
            dec = UNI_CAP_STEP * (int'(h) - RELEASE_HOUR);
            if (dec >= UNI_CAP_BASE - UNI_CAP_MIN) begin
                return CW'(UNI_CAP_MIN);
            end else begin
                return CW'(UNI_CAP_BASE - dec);
            end
        end
    endfunction

    assign w_tick = (r_presc == PW'(CLKS_PER_HOUR - 1));

    // Entry/exit decisions and next-cycle free space; acceptance uses the registered free counts
    always_comb begin
        w_uni_inc = 1'b0;
        w_uni_dec = 1'b0;
        w_pub_inc = 1'b0;
        w_pub_dec = 1'b0;
        w_rej_nxt = 1'b0;
        w_err_nxt = 1'b0;
        if (car_entered) begin
            if (is_uni_car_entered) begin
                if (r_uni_vac != {CW{1'b0}}) w_uni_inc = 1'b1;
                else                         w_rej_nxt = 1'b1;
            end else begin
                if (r_pub_vac != {CW{1'b0}}) w_pub_inc = 1'b1;
                else                         w_rej_nxt = 1'b1;
            end
        end else begin
            w_rej_nxt = 1'b0;
        end
        if (car_exited) begin
            if (is_uni_car_exited) begin
                if (r_uni_cnt != {CW{1'b0}}) w_uni_dec = 1'b1;
                else                         w_err_nxt = 1'b1;
            end else begin
                if (r_pub_cnt != {CW{1'b0}}) w_pub_dec = 1'b1;
                else                         w_err_nxt = 1'b1;
            end
        end else begin
            w_err_nxt = 1'b0;
        end
        w_uni_cnt_nxt = r_uni_cnt + CW'(w_uni_inc) - CW'(w_uni_dec);
        w_pub_cnt_nxt = r_pub_cnt + CW'(w_pub_inc) - CW'(w_pub_dec);

        // Capacity follows the hour currently held, so a new hour shows up one edge later
        w_uni_cap = uni_cap_f(r_hour);
        if (w_uni_cap >= w_uni_cnt_nxt) w_pub_cap = CW'(CAP_TOTAL) - w_uni_cap;
        else                            w_pub_cap = CW'(CAP_TOTAL) - w_uni_cnt_nxt;
        if (w_uni_cap > w_uni_cnt_nxt) w_uni_vac_nxt = w_uni_cap - w_uni_cnt_nxt;
        else                           w_uni_vac_nxt = {CW{1'b0}};
        if (w_pub_cap > w_pub_cnt_nxt) w_pub_vac_nxt = w_pub_cap - w_pub_cnt_nxt;
        else                           w_pub_vac_nxt = {CW{1'b0}};
    end

    // Prescaler, hour counter, occupancy counts and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc     <= {PW{1'b0}};
            r_hour      <= 5'(START_HOUR);
            r_uni_cnt   <= {CW{1'b0}};
            r_pub_cnt   <= {CW{1'b0}};
            r_uni_vac   <= CW'(UNI_CAP_BASE);
            r_pub_vac   <= CW'(CAP_TOTAL - UNI_CAP_BASE);
            r_uni_flag  <= 1'b1;
            r_pub_flag  <= 1'b1;
            r_entry_rej <= 1'b0;
            r_exit_err  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= {PW{1'b0}};
                if (r_hour == 5'(END_HOUR)) r_hour <= 5'(START_HOUR);
                else                        r_hour <= r_hour + 5'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_uni_cnt   <= w_uni_cnt_nxt;
            r_pub_cnt   <= w_pub_cnt_nxt;
            r_uni_vac   <= w_uni_vac_nxt;
            r_pub_vac   <= w_pub_vac_nxt;
            r_uni_flag  <= (w_uni_vac_nxt != {CW{1'b0}});
            r_pub_flag  <= (w_pub_vac_nxt != {CW{1'b0}});
            r_entry_rej <= w_rej_nxt;
            r_exit_err  <= w_err_nxt;
        end
    end

    assign uni_parked_cars      = r_uni_cnt;
    assign parked_cars          = r_pub_cnt;
    assign uni_vacated_space    = r_uni_vac;
    assign vacated_space        = r_pub_vac;
    assign uni_is_vacated_space = r_uni_flag;
    assign is_vacated_space     = r_pub_flag;
    assign hour                 = r_hour;
    assign entry_rejected       = r_entry_rej;
    assign exit_error           = r_exit_err;

endmodule

// File: doc/parking_ctrl_p.md
PARKING_CTRL_P -- requirements
Module: parking_ctrl_p

Interface
REQ-001 SHALL have parameter CAP_TOTAL, default 700, meaning total parking slots.
REQ-002 SHALL have parameter UNI_CAP_BASE, default 500, meaning slots reserved for university cars up to RELEASE_HOUR.
REQ-003 SHALL have parameter UNI_CAP_STEP, default 50, meaning slots released from university to public per hour after RELEASE_HOUR.
REQ-004 SHALL have parameter UNI_CAP_MIN, default 200, meaning floor on the university reservation.
REQ-005 SHALL have parameter RELEASE_HOUR, default 13, meaning last hour at the full reservation.
REQ-006 SHALL have parameters START_HOUR, default 8, and END_HOUR, default 24, meaning the first and last displayed hour.
REQ-007 SHALL have parameter CLKS_PER_HOUR, default 1, meaning clock cycles per hour tick (>=1).
REQ-008 SHALL have parameter CW, default 10, meaning counter width (2^CW > CAP_TOTAL).
REQ-009 clk  in  1  single clock; all state updates on rising edge.
REQ-010 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-011 car_entered  in  1  entry request this cycle.
REQ-012 is_uni_car_entered  in  1  entry request is a university car (qualified by car_entered).
REQ-013 car_exited  in  1  exit event this cycle.
REQ-014 is_uni_car_exited  in  1  exit event is a university car (qualified by car_exited).
REQ-015 uni_parked_cars  out  CW  university cars parked.
REQ-016 parked_cars  out  CW  public cars parked.
REQ-017 uni_vacated_space  out  CW  free university slots.
REQ-018 vacated_space  out  CW  free public slots.
REQ-019 uni_is_vacated_space / is_vacated_space  out  1 each  corresponding free count nonzero.
REQ-020 hour  out  5  current hour.
REQ-021 entry_rejected / exit_error  out  1 each  one-cycle pulses (new vs. predecessor block).

Function
REQ-022 Prescaler SHALL count 0..CLKS_PER_HOUR-1; at terminal count hour SHALL increment, and END_HOUR SHALL be followed by START_HOUR.
REQ-023 uni_cap SHALL be UNI_CAP_BASE for hour<=RELEASE_HOUR, else max(UNI_CAP_MIN, UNI_CAP_BASE-UNI_CAP_STEP*(hour-RELEASE_HOUR)).
REQ-024 pub_cap SHALL be CAP_TOTAL - max(uni_cap, uni_parked_cars); parked university cars are never evicted.
REQ-025 uni_vacated_space SHALL be uni_cap-uni_parked_cars saturated at 0; vacated_space SHALL be pub_cap-parked_cars saturated at 0.
REQ-026 An entry SHALL be accepted iff the target zone's free count, evaluated on pre-edge state, is nonzero; the count SHALL then increment at the edge.
REQ-027 A refused entry SHALL leave counts unchanged and SHALL pulse entry_rejected high for exactly the following cycle; no university-to-public overflow.
REQ-028 An exit SHALL decrement the target zone's count if it is nonzero; if it is zero, counts SHALL stay unchanged and exit_error SHALL pulse for one cycle.
REQ-029 Simultaneous entry and exit SHALL both be applied in one edge; entry acceptance SHALL use pre-edge free space (a same-cycle exit does not free a slot for the entry).
REQ-030 All outputs SHALL be registered, and hour-dependent capacity SHALL take effect on the edge after the hour changes.
REQ-031 Counts SHALL persist across the END_HOUR->START_HOUR rollover.

Reset
REQ-032 While reset=0, hour=START_HOUR, the prescaler=0, both counts=0, uni_vacated_space=UNI_CAP_BASE, vacated_space=CAP_TOTAL-UNI_CAP_BASE, both is_* flags=1, and both pulses=0.
REQ-033 Reset asserted mid-operation SHALL clear state immediately; the first hour tick SHALL come CLKS_PER_HOUR edges after release.

Verification (defaults, CLKS_PER_HOUR=1)
REQ-034 Release reset, 3 university entries -> uni_parked_cars=3, uni_vacated_space=497, hour=11.
REQ-035 Reach hour 16 with uni_parked_cars=0 -> uni_vacated_space=350, vacated_space=350; hour 19+ -> 200/500.
REQ-036 Fill public zone to 200 at hour 9, then one more public entry -> entry_rejected pulse, parked_cars stays 200, is_vacated_space=0.
REQ-037 University exit with uni_parked_cars=0 -> exit_error pulse, counts unchanged.
REQ-038 Public zone full while a public entry and a public exit occur in the same cycle -> entry rejected, parked_cars decrements by 1.
REQ-039 Run through hour 24 -> next hour=8 with counts retained; reset pulse mid-run -> all REQ-032 values.
